// File: rtl/digit_scan_display.sv
// ============================================================================
// Module   : digit_scan_display
// Purpose  : Four-digit multiplexed seven-segment scanner with per-frame
//            snapshot of the digit inputs. Optional cursor blink is built
//            when CURSOR_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_scan_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       display_en,
  input  logic [1:0] cursor,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [3:0] ftsd_ctl,
  output logic [7:0] ftsd
);

  localparam logic [15:0] c_scan_last = 16'(SCAN_DIV - 1);

  function automatic logic [7:0] f_decode(input logic [3:0] v);
    logic [7:0] seg;
    case (v)
      4'h0: seg = 8'h03;  4'h1: seg = 8'h9F;  4'h2: seg = 8'h25;  4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h49;  4'h6: seg = 8'h41;  4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;  4'h9: seg = 8'h09;  4'hA: seg = 8'h11;  4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;  4'hD: seg = 8'h85;  4'hE: seg = 8'h61;  default: seg = 8'h71;
    endcase
    return seg;
  endfunction

  logic [15:0] r_scan_cnt;
  logic [1:0]  r_idx;
  logic        r_init_pending;
  logic [3:0]  r_snap [4];
  logic        w_tick;
  logic        w_frame_end;
  logic        w_blank;
  logic [3:0]  w_cur_digit;

  assign w_tick      = (r_scan_cnt == c_scan_last);
  assign w_frame_end = w_tick && (r_idx == 2'd3);
  assign w_cur_digit = r_snap[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt     <= 16'd0;
      r_idx          <= 2'd0;
      r_init_pending <= 1'b1;
      for (int i = 0; i < 4; i++) r_snap[i] <= 4'd0;
    end else begin
      r_init_pending <= 1'b0;
      r_scan_cnt     <= w_tick ? 16'd0 : r_scan_cnt + 16'd1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      // Digits are captured only between frames so a frame never tears.
      if (w_frame_end || r_init_pending) begin
        r_snap[0] <= digit0;
        r_snap[1] <= digit1;
        r_snap[2] <= digit2;
        r_snap[3] <= digit3;
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam logic [7:0] c_blink_last = 8'(BLINK_FRAMES - 1);

  logic [7:0] r_blink_cnt;
  logic       r_blink_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= 8'd0;
      r_blink_off <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= 8'd0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign w_blank = r_blink_off && (r_idx == cursor);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cursor, 8'(BLINK_FRAMES)};
  assign w_blank      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftsd_ctl <= 4'b1111;
      ftsd     <= 8'hFF;
    end else if (display_en) begin
      ftsd_ctl <= ~(4'b0001 << r_idx);
      ftsd     <= w_blank ? 8'hFF : f_decode(w_cur_digit);
    end else begin
      ftsd_ctl <= 4'b1111;
      ftsd     <= 8'hFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_display.sv
// Bench for digit_scan_display: elapsed-cycle reference model plus directed
// literal checks; honours CURSOR_BLINK_EN the same way the design does.
`default_nettype none

module tb_digit_scan_display;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       display_en = 1'b0;
  logic [1:0] cursor = 2'd0;
  logic [3:0] digit0 = 4'd0, digit1 = 4'd0, digit2 = 4'd0, digit3 = 4'd0;
  logic [3:0] ftsd_ctl;
  logic [7:0] ftsd;

  int n_vec = 0;
  int n_err = 0;

  digit_scan_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .display_en(display_en), .cursor(cursor),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .ftsd_ctl(ftsd_ctl), .ftsd(ftsd)
  );

  always #5 clk = ~clk;

  logic [7:0] dec_tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got ctl=%b seg=%h, expected ctl=%b seg=%h",
               nm, $time, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  // Reference model: k = edges since reset release. Before edge k the slot is
  // ((k-1)/SD)%4 and (k-1)/(4*SD) frame ends have already happened.
  int         k = 0;
  logic [3:0] m_snap [4];
  logic [3:0] exp_ctl = 4'hF;
  logic [7:0] exp_seg = 8'hFF;

  always @(posedge clk) begin
    int j, idx, frames;
    bit boff;
    if (!rst_n) begin
      k = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
      exp_ctl = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      j = k;
      k++;
      idx = (j / SD) % 4;
      frames = j / (4 * SD);
`ifdef CURSOR_BLINK_EN
      boff = ((frames / BF) % 2) == 1;
`else
      boff = 1'b0;
`endif
      if (display_en) begin
        exp_ctl = ~(4'b0001 << idx);
        exp_seg = (boff && idx == int'(cursor)) ? 8'hFF : dec_tbl[m_snap[idx]];
      end else begin
        exp_ctl = 4'hF;
        exp_seg = 8'hFF;
      end
      if (k == 1 || (j % (4 * SD)) == 4 * SD - 1) begin
        m_snap[0] = digit0; m_snap[1] = digit1; m_snap[2] = digit2; m_snap[3] = digit3;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cycle", {ftsd_ctl, ftsd}, {exp_ctl, exp_seg});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] lit_frame0(input int n);
    if (n == 1)       return {4'b1110, 8'h03};
    else if (n <= 4)  return {4'b1110, 8'h9F};
    else if (n <= 8)  return {4'b1101, 8'h25};
    else if (n <= 12) return {4'b1011, 8'h0D};
    else              return {4'b0111, 8'h99};
  endfunction

  initial begin
    logic [11:0] blink_exp;
    int guard;
    repeat (2) step();
    chk("reset_hold", {ftsd_ctl, ftsd}, 12'hFFF);

    // Release with digits 1,2,3,4.
    @(negedge clk);
    digit0 = 4'h1; digit1 = 4'h2; digit2 = 4'h3; digit3 = 4'h4;
    display_en = 1'b1; cursor = 2'd0;
    rst_n = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      step();
      if (n <= 16) chk("frame0_seq", {ftsd_ctl, ftsd}, lit_frame0(n));
      if (n >= 25 && n <= 28) chk("no_tear_pos2", {ftsd_ctl, ftsd}, {4'b1011, 8'h0D});
      if (n >= 33 && n <= 36) begin
`ifdef CURSOR_BLINK_EN
        blink_exp = {4'b1110, 8'hFF};
`else
        blink_exp = {4'b1110, 8'h9F};
`endif
        chk("cursor_blink_pos0", {ftsd_ctl, ftsd}, blink_exp);
      end
      if (n >= 41 && n <= 44) chk("new_frame_pos2", {ftsd_ctl, ftsd}, {4'b1011, 8'h61});
      if (n == 18) begin
        @(negedge clk);
        digit2 = 4'hE;
      end
    end

    // Disable during slot 1, re-enable after six blanked edges.
    while (k < 55) step();
    @(negedge clk);
    display_en = 1'b0;
    step();
    chk("disable_next_edge", {ftsd_ctl, ftsd}, 12'hFFF);
    while (k < 61) step();
    @(negedge clk);
    display_en = 1'b1;
    step();
    chk("reenable_slot3", {ftsd_ctl, ftsd}, {4'b0111, 8'h99});

    // Sweep every hex value through digit0, one frame each.
    cursor = 2'd3;
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      digit0 = 4'(v);
      repeat (4 * SD) step();
    end

    // Randomized traffic.
    cursor = 2'd2;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: digit0 = 4'($urandom);
          1: digit1 = 4'($urandom);
          2: digit2 = 4'($urandom);
          default: digit3 = 4'($urandom);
        endcase
      end
      if ($urandom_range(39) == 0) display_en = ~display_en;
      if ($urandom_range(199) == 0) cursor = 2'($urandom);
      step();
    end

    // Asynchronous reset mid-slot while in slot 2.
    @(negedge clk);
    display_en = 1'b1;
    guard = 0;
    while (!(((k / SD) % 4) == 2 && (k % SD) == 1) && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) begin
      n_vec++; n_err++;
      $display("FAIL slot2_wait: got timeout, expected slot 2 within 64 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {ftsd_ctl, ftsd}, 12'hFFF);
    step();
    @(negedge clk);
    digit0 = 4'h7;
    rst_n = 1'b1;
    step();
    chk("rerelease_edge1", {ftsd_ctl, ftsd}, {4'b1110, 8'h03});
    step();
    chk("rerelease_edge2", {ftsd_ctl, ftsd}, {4'b1110, 8'h1F});
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
